apb_regfile: RTL and testbench

Parametrised APB slave register file, the next generation of our single-register APB write target. It adds read-back, byte strobes, configurable wait states and error response. It sits behind the CPU-model APB master and exposes its register contents to downstream logic as a flat output bus. An optional built-in protocol monitor flags master-side APB violations.

---
 rtl/apb_regfile.sv | 242 ++++++++++++++++++++++++
 tb/tb_apb_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile.sv
// APB slave register file with byte strobes, wait states and error response.
// Define APB_REGFILE_PROT_CHECK_EN to build in the master-side protocol monitor.
module apb_regfile #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                         pclk,
   input  logic                         preset,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o,
   output logic                         proto_err
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_W - OFF_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                wr_q, wr_d;
   logic                oor_q, oor_d;
   logic [DATA_W-1:0]   prdata_q, prdata_d;
   logic                pslverr_q, pslverr_d;
   logic                pready_q, pready_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   rd_word_s;
   logic                enter_resp_s;

   function automatic logic in_range(input logic [IDX_W-1:0] idx);
      return (32'(idx) < NUM_REGS);
   endfunction

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_w;
      for (int unsigned i = 0; i < STRB_W; i++) begin
         if (strb[i]) begin
            res[i*8 +: 8] = new_w[i*8 +: 8];
         end else begin
            res[i*8 +: 8] = old_w[i*8 +: 8];
         end
      end
      return res;
   endfunction

   // Transfer FSM, byte-lane write merge and registered response generation
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      wr_d         = wr_q;
      oor_d        = oor_q;
      prdata_d     = '0;
      pslverr_d    = 1'b0;
      pready_d     = 1'b0;
      regs_d       = regs_q;
      rd_word_s    = '0;
      enter_resp_s = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               idx_d = paddr[ADDR_W-1:OFF_W];
               wr_d  = pwrite;
               oor_d = !in_range(paddr[ADDR_W-1:OFF_W]);
               if (WAIT_STATES == 0) begin
                  state_d      = S_RESP;
                  enter_resp_s = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            // A dropped psel is a master abort: leave without touching the registers
            if (!psel) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               state_d      = S_RESP;
               cnt_d        = 4'd0;
               enter_resp_s = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (wr_q && !oor_q) begin
               for (int unsigned k = 0; k < NUM_REGS; k++) begin
                  if (32'(idx_q) == k) begin
                     regs_d[k] = merge_bytes(regs_q[k], pwdata, pstrb);
                  end else begin
                     regs_d[k] = regs_q[k];
                  end
               end
            end else begin
               regs_d = regs_q;
            end
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      for (int unsigned k = 0; k < NUM_REGS; k++) begin
         if (32'(idx_d) == k) begin
            rd_word_s = regs_q[k];
         end else begin
            rd_word_s = rd_word_s;
         end
      end

      if (enter_resp_s) begin
         pready_d  = 1'b1;
         pslverr_d = oor_d;
         prdata_d  = (!wr_d && !oor_d) ? rd_word_s : '0;
      end else begin
         pready_d  = 1'b0;
      end
   end

   // State, response and register-array flops
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         oor_q     <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         pready_q  <= 1'b0;
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         oor_q     <= oor_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         pready_q  <= pready_d;
         regs_q    <= regs_d;
      end
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
      assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
   end

`ifdef APB_REGFILE_PROT_CHECK_EN
   logic [ADDR_W-1:0] sh_addr_q, sh_addr_d;
   logic [DATA_W-1:0] sh_wdata_q, sh_wdata_d;
   logic [STRB_W-1:0] sh_strb_q, sh_strb_d;
   logic              sh_wr_q, sh_wr_d;
   logic              proto_err_q, proto_err_d;
   logic              viol_s;

   // Shadow the setup-phase controls and flag any master-side deviation
   always_comb begin
      sh_addr_d  = sh_addr_q;
      sh_wdata_d = sh_wdata_q;
      sh_strb_d  = sh_strb_q;
      sh_wr_d    = sh_wr_q;
      viol_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (penable) begin
               viol_s = 1'b1;
            end else if (psel) begin
               sh_addr_d  = paddr;
               sh_wdata_d = pwdata;
               sh_strb_d  = pstrb;
               sh_wr_d    = pwrite;
            end else begin
               viol_s = 1'b0;
            end
         end
         S_WAIT, S_RESP: begin
            viol_s = !psel || (paddr != sh_addr_q) || (pwdata != sh_wdata_q) ||
                     (pstrb != sh_strb_q) || (pwrite != sh_wr_q);
         end
         default: begin
            viol_s = 1'b0;
         end
      endcase
      proto_err_d = proto_err_q | viol_s;
   end

   // Monitor flops; the error flag is sticky until reset
   always_ff @(posedge pclk) begin
      if (preset) begin
         sh_addr_q   <= '0;
         sh_wdata_q  <= '0;
         sh_strb_q   <= '0;
         sh_wr_q     <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         sh_addr_q   <= sh_addr_d;
         sh_wdata_q  <= sh_wdata_d;
         sh_strb_q   <= sh_strb_d;
         sh_wr_q     <= sh_wr_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile.sv
// Scoreboard bench for apb_regfile: a 0-wait-state instance and a 3-wait-state instance.
`timescale 1ns/1ps
module tb_apb_regfile;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   logic         pclk = 1'b0;
   logic         preset_s  [2];
   logic         psel_s    [2];
   logic         penable_s [2];
   logic         pwrite_s  [2];
   logic [7:0]   paddr_s   [2];
   logic [31:0]  pwdata_s  [2];
   logic [3:0]   pstrb_s   [2];
   logic [31:0]  prdata_s  [2];
   logic         pready_s  [2];
   logic         pslverr_s [2];
   logic [511:0] regs_s    [2];
   logic         proto_s   [2];

   int           ws [2] = '{0, 3};
   int           cyc = 0;
   int           n_checks = 0;
   int           n_errors = 0;
   exp_t         sb0 [$];
   exp_t         sb1 [$];
   logic [511:0] eb0 = '0;
   logic [511:0] eb1 = '0;

`ifdef APB_REGFILE_PROT_CHECK_EN
   localparam logic PROT_EXP = 1'b1;
`else
   localparam logic PROT_EXP = 1'b0;
`endif

   apb_regfile #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
      .pclk(pclk), .preset(preset_s[0]), .psel(psel_s[0]), .penable(penable_s[0]),
      .pwrite(pwrite_s[0]), .paddr(paddr_s[0]), .pwdata(pwdata_s[0]), .pstrb(pstrb_s[0]),
      .prdata(prdata_s[0]), .pready(pready_s[0]), .pslverr(pslverr_s[0]),
      .regs_o(regs_s[0]), .proto_err(proto_s[0]));

   apb_regfile #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(8), .WAIT_STATES(3)) u_dut3 (
      .pclk(pclk), .preset(preset_s[1]), .psel(psel_s[1]), .penable(penable_s[1]),
      .pwrite(pwrite_s[1]), .paddr(paddr_s[1]), .pwdata(pwdata_s[1]), .pstrb(pstrb_s[1]),
      .prdata(prdata_s[1]), .pready(pready_s[1]), .pslverr(pslverr_s[1]),
      .regs_o(regs_s[1]), .proto_err(proto_s[1]));

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_bus(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic void push(input int d, input logic [31:0] rd, input logic err, input int c);
      exp_t e;
      e.rd = rd;
      e.err = err;
      e.cyc = c;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endfunction

   // Monitor: every pready pulse must match the oldest expected response
   always @(negedge pclk) begin
      for (int d = 0; d < 2; d++) begin
         if (pready_s[d]) begin
            exp_t e;
            n_checks++;
            if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
               n_errors++;
               $display("FAIL unexpected_pready dut%0d: got pready=1, expected no response", d);
            end else begin
               if (d == 0) e = sb0.pop_front();
               else        e = sb1.pop_front();
               chk($sformatf("prdata dut%0d", d), 64'(prdata_s[d]), 64'(e.rd));
               chk($sformatf("pslverr dut%0d", d), 64'(pslverr_s[d]), 64'(e.err));
               chk($sformatf("latency dut%0d", d), 64'(cyc), 64'(e.cyc));
            end
         end else begin
            chk($sformatf("idle_resp dut%0d", d), {31'd0, pslverr_s[d], prdata_s[d]}, 64'd0);
         end
      end
   end

   task automatic wait_ready(input int d);
      int n;
      n = 0;
      while (!pready_s[d] && n < 40) begin
         @(posedge pclk); #1;
         n++;
      end
      if (!pready_s[d]) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout dut%0d: got no pready, expected pready within 40 cycles", d);
      end
   endtask

   // Returns during the response cycle so a following call issues a back-to-back setup
   task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] erd, input logic eerr);
      @(posedge pclk); #1;
      psel_s[d] = 1'b1; penable_s[d] = 1'b0; pwrite_s[d] = wr;
      paddr_s[d] = a; pwdata_s[d] = wd; pstrb_s[d] = st;
      push(d, erd, eerr, cyc + 1 + ws[d]);
      @(posedge pclk); #1;
      penable_s[d] = 1'b1;
      wait_ready(d);
   endtask

   task automatic idle(input int d);
      @(posedge pclk); #1;
      psel_s[d] = 1'b0; penable_s[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         preset_s[d] = 1'b1; psel_s[d] = 1'b0; penable_s[d] = 1'b0; pwrite_s[d] = 1'b0;
         paddr_s[d] = 8'h00; pwdata_s[d] = 32'h0; pstrb_s[d] = 4'h0;
      end
      repeat (3) @(posedge pclk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_out dut%0d", d),
             {29'd0, pready_s[d], pslverr_s[d], proto_s[d], prdata_s[d]}, 64'd0);
         chk_bus($sformatf("rst_regs dut%0d", d), regs_s[d], 512'd0);
         preset_s[d] = 1'b0;
      end

      // Zero wait states: plain read, strobed writes, offset bits, out-of-range, last index
      xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0);
      xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'b0101, 32'h0, 1'b0);
      idle(0);
      eb0[64 +: 32] = 32'h00AD00EF;
      chk("regs_o_95_64", 64'(regs_s[0][95:64]), 64'h00AD00EF);
      xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 32'h00AD00EF, 1'b0);
      xfer(0, 1'b1, 8'h09, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b1, 8'h08, 32'h11223344, 4'b1010, 32'h0, 1'b0);
      xfer(0, 1'b0, 8'h0B, 32'h0, 4'h0, 32'h11FE330D, 1'b0);
      idle(0);
      eb0[64 +: 32] = 32'h11FE330D;
      chk_bus("regs_after_strobes", regs_s[0], eb0);
      xfer(0, 1'b1, 8'h40, 32'h00001234, 4'hF, 32'h0, 1'b1);
      xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, 32'h0, 1'b1);
      xfer(0, 1'b0, 8'hFF, 32'h0, 4'h0, 32'h0, 1'b1);
      idle(0);
      chk_bus("regs_after_oor", regs_s[0], eb0);
      xfer(0, 1'b1, 8'h3C, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
      xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
      idle(0);
      eb0[480 +: 32] = 32'hA5A5A5A5;
      chk_bus("regs_last_index", regs_s[0], eb0);
      chk("proto_dut0", 64'(proto_s[0]), 64'd0);

      // Three wait states: write then read
      xfer(1, 1'b1, 8'h04, 32'h89ABCDEF, 4'hF, 32'h0, 1'b0);
      xfer(1, 1'b0, 8'h04, 32'h0, 4'h0, 32'h89ABCDEF, 1'b0);
      idle(1);
      eb1[32 +: 32] = 32'h89ABCDEF;
      chk_bus("regs_ws3", regs_s[1], eb1);

      // Reset in the middle of a waited write
      @(posedge pclk); #1;
      psel_s[1] = 1'b1; penable_s[1] = 1'b0; pwrite_s[1] = 1'b1;
      paddr_s[1] = 8'h10; pwdata_s[1] = 32'hFFFFFFFF; pstrb_s[1] = 4'hF;
      @(posedge pclk); #1;
      penable_s[1] = 1'b1;
      @(posedge pclk); #1;
      preset_s[1] = 1'b1; psel_s[1] = 1'b0; penable_s[1] = 1'b0;
      @(posedge pclk); #1;
      eb1 = '0;
      chk("midrst_out", {29'd0, pready_s[1], pslverr_s[1], proto_s[1], prdata_s[1]}, 64'd0);
      chk_bus("midrst_regs", regs_s[1], eb1);
      preset_s[1] = 1'b0;
      xfer(1, 1'b1, 8'h10, 32'h0000005A, 4'b0001, 32'h0, 1'b0);
      xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0000005A, 1'b0);
      idle(1);
      eb1[128 +: 32] = 32'h0000005A;
      chk_bus("regs_after_midrst", regs_s[1], eb1);
      chk("proto_clean", 64'(proto_s[1]), 64'd0);

      // pwdata changes during the wait phase; the write lands with the response-cycle value
      @(posedge pclk); #1;
      psel_s[1] = 1'b1; penable_s[1] = 1'b0; pwrite_s[1] = 1'b1;
      paddr_s[1] = 8'h14; pwdata_s[1] = 32'h01020304; pstrb_s[1] = 4'hF;
      push(1, 32'h0, 1'b0, cyc + 4);
      @(posedge pclk); #1;
      penable_s[1] = 1'b1;
      @(posedge pclk); #1;
      pwdata_s[1] = 32'h0A0B0C0D;
      wait_ready(1);
      idle(1);
      eb1[160 +: 32] = 32'h0A0B0C0D;
      chk_bus("regs_after_proto", regs_s[1], eb1);
      chk("proto_set", 64'(proto_s[1]), 64'(PROT_EXP));
      xfer(1, 1'b0, 8'h14, 32'h0A0B0C0D, 4'h0, 32'h0A0B0C0D, 1'b0);
      idle(1);
      chk("proto_sticky", 64'(proto_s[1]), 64'(PROT_EXP));
      @(posedge pclk); #1;
      preset_s[1] = 1'b1;
      @(posedge pclk); #1;
      chk("proto_rst", 64'(proto_s[1]), 64'd0);
      preset_s[1] = 1'b0;

      repeat (3) @(posedge pclk);
      #1;
      chk("sb0_drained", 64'(sb0.size()), 64'd0);
      chk("sb1_drained", 64'(sb1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
